// File: rtl/bullet_slot_ctrl.sv
// Player bullet slot allocator: per frame moves, kills and spawns bullets.
// Ports: clk/rstn, frame_tick, game, fire, player_x/y, hit -> exist/x/y, pulses, state.
module bullet_slot_ctrl #(
  parameter int NSLOT    = 5,
  parameter int SPEED    = 4,
  parameter int X_MAX    = 400,
  parameter int DX       = 32,
  parameter int DY       = 12,
  parameter int COOLDOWN = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 frame_tick,
  input  logic                 game,
  input  logic                 fire,
  input  logic [8:0]           player_x,
  input  logic [8:0]           player_y,
  input  logic [NSLOT-1:0]     hit,
  output logic [NSLOT-1:0]     exist_bullet,
  output logic [9*NSLOT-1:0]   bullet_x,
  output logic [9*NSLOT-1:0]   bullet_y,
  output logic                 fire_ack,
  output logic                 fire_drop,
  output logic [1:0]           state
);

  localparam int CW = $clog2(COOLDOWN + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READY = 2'b01,
    COOL  = 2'b10
  } st_t;

  st_t                   st_q, st_n;
  logic [CW-1:0]         cnt_q, cnt_n;
  logic [NSLOT-1:0]      ex_q, ex_n;
  logic [NSLOT-1:0][8:0] bx_q, bx_n;
  logic [NSLOT-1:0][8:0] by_q, by_n;
  logic                  ack_q, ack_n;
  logic                  drop_q, drop_n;

  logic [9:0]            nx;
  logic [9:0]            sx;
  logic                  found;
  logic [NSLOT-1:0]      pick;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      st_q   <= IDLE;
      cnt_q  <= '0;
      ex_q   <= '0;
      bx_q   <= '0;
      by_q   <= '0;
      ack_q  <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      st_q   <= st_n;
      cnt_q  <= cnt_n;
      ex_q   <= ex_n;
      bx_q   <= bx_n;
      by_q   <= by_n;
      ack_q  <= ack_n;
      drop_q <= drop_n;
    end
  end

  always_comb begin
    st_n   = st_q;
    cnt_n  = cnt_q;
    ex_n   = ex_q;
    bx_n   = bx_q;
    by_n   = by_q;
    ack_n  = 1'b0;
    drop_n = 1'b0;
    nx     = '0;
    sx     = {1'b0, player_x} + 10'(DX);
    found  = 1'b0;
    pick   = '0;

    if (!game || st_q == IDLE) begin
      ex_n  = '0;
      bx_n  = '0;
      by_n  = '0;
      cnt_n = '0;
      st_n  = game ? READY : IDLE;
    end else begin
      if (frame_tick) begin
        for (int i = 0; i < NSLOT; i++) begin
          if (ex_q[i]) begin
            nx = {1'b0, bx_q[i]} + 10'(SPEED);
            // retired bullets keep their last x
            if (nx >= 10'(X_MAX))
              ex_n[i] = 1'b0;
            else
              bx_n[i] = nx[8:0];
          end
        end
      end

      ex_n = ex_n & ~hit;

      // lowest free slot after move and kills
      for (int i = 0; i < NSLOT; i++) begin
        if (!found && !ex_n[i]) begin
          found   = 1'b1;
          pick[i] = 1'b1;
        end
      end

      if (frame_tick) begin
        unique case (st_q)
          READY: begin
            if (fire) begin
              if (found && sx < 10'(X_MAX)) begin
                for (int i = 0; i < NSLOT; i++) begin
                  if (pick[i]) begin
                    ex_n[i] = 1'b1;
                    bx_n[i] = sx[8:0];
                    by_n[i] = player_y + 9'(DY);
                  end
                end
                ack_n = 1'b1;
                st_n  = COOL;
                cnt_n = CW'(COOLDOWN - 1);
              end else begin
                drop_n = 1'b1;
              end
            end
          end
          COOL: begin
            if (cnt_q == '0)
              st_n = READY;
            else
              cnt_n = cnt_q - 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign exist_bullet = ex_q;
  assign bullet_x     = bx_q;
  assign bullet_y     = by_q;
  assign fire_ack     = ack_q;
  assign fire_drop    = drop_q;
  assign state        = st_q;

endmodule
